// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver for the UART16550 block.
// Oversamples the synchronised rx line with a divisor-driven cycle counter,
// samples each bit near its centre, pushes completed bytes into the RX FIFO
// and reports framing, overrun and break conditions as single-cycle pulses.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] DLM,
    input  logic [7:0] DLL,
    input  logic       rx_i,
    input  logic       fifo_full,
    output logic       fifo_wr_en,
    output logic [7:0] fifo_wr_data,
    output logic       framing_err_o,
    output logic       overrun_o,
    output logic       break_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    // Synchroniser chain; the last stage is the line value all decisions use.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rx_s;
    logic                   rx_d_q;
    logic                   rx_d_d;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [2:0]  bit_idx_q;
    logic [2:0]  bit_idx_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;

    logic        fifo_wr_en_q;
    logic        fifo_wr_en_d;
    logic [7:0]  fifo_wr_data_q;
    logic [7:0]  fifo_wr_data_d;
    logic        framing_err_q;
    logic        framing_err_d;
    logic        overrun_q;
    logic        overrun_d;
    logic        break_q;
    logic        break_d;

    // Bit period is N = {DLM,DLL} (a zero divisor behaves as N = 1).
    // bit_last = N-1 is the last cycle of a bit; half_point = (N-1)>>1.
    logic [15:0] divisor;
    logic [15:0] bit_last;
    logic [15:0] half_point;

    assign divisor    = {DLM, DLL};
    assign bit_last   = (divisor == 16'd0) ? 16'd0 : (divisor - 16'd1);
    assign half_point = bit_last >> 1;

    // Shift chain input: stage 0 takes the raw pin, each later stage the previous one.
    assign sync_d[0] = rx_i;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign rx_d_d = rx_s;

    // Next-state, counter, shift register and pulse generation for the frame FSM.
    // Counter compares use >= so a divisor lowered mid-frame can never strand
    // the counter above its target; with a stable divisor this equals ==.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + 16'd1;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        fifo_wr_en_d   = 1'b0;
        fifo_wr_data_d = fifo_wr_data_q;
        framing_err_d  = 1'b0;
        overrun_d      = 1'b0;
        break_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (rx_d_q && !rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q >= half_point) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        // Line went back high by mid start bit: treat as a glitch.
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end

            S_DATA: begin
                if (cnt_q >= bit_last) begin
                    cnt_d              = 16'd0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            S_STOP: begin
                if (cnt_q >= bit_last) begin
                    cnt_d = 16'd0;
                    if (fifo_full) begin
                        overrun_d = 1'b1;
                    end else begin
                        fifo_wr_en_d   = 1'b1;
                        fifo_wr_data_d = shift_q;
                    end
                    if (rx_s) begin
                        // Return to IDLE while the stop bit is still high so an
                        // immediately following start edge is caught.
                        state_d = S_IDLE;
                    end else begin
                        framing_err_d = 1'b1;
                        break_d       = (shift_q == 8'h00);
                        state_d       = S_WAIT_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                // A held-low line must produce one event only, so wait for high.
                cnt_d = 16'd0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                cnt_d   = 16'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns the line model to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q         <= '1;
            rx_d_q         <= 1'b1;
            state_q        <= S_IDLE;
            cnt_q          <= 16'd0;
            bit_idx_q      <= 3'd0;
            shift_q        <= 8'h00;
            fifo_wr_en_q   <= 1'b0;
            fifo_wr_data_q <= 8'h00;
            framing_err_q  <= 1'b0;
            overrun_q      <= 1'b0;
            break_q        <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            rx_d_q         <= rx_d_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            fifo_wr_en_q   <= fifo_wr_en_d;
            fifo_wr_data_q <= fifo_wr_data_d;
            framing_err_q  <= framing_err_d;
            overrun_q      <= overrun_d;
            break_q        <= break_d;
        end
    end

    assign fifo_wr_en    = fifo_wr_en_q;
    assign fifo_wr_data  = fifo_wr_data_q;
    assign framing_err_o = framing_err_q;
    assign overrun_o     = overrun_q;
    assign break_o       = break_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomised frames driven on rx_i, DUT events
// collected by a monitor and compared against a frame-level reference model.
module tb_uart_rx;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] DLM = 8'h00;
    logic [7:0] DLL = 8'h10;
    logic       rx_i = 1'b1;
    logic       fifo_full = 1'b0;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       framing_err_o;
    logic       overrun_o;
    logic       break_o;
    logic       busy_o;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       fe;
        logic       ov;
        logic       brk;
        int         t;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];

    uart_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .DLM          (DLM),
        .DLL          (DLL),
        .rx_i         (rx_i),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .framing_err_o(framing_err_o),
        .overrun_o    (overrun_o),
        .break_o      (break_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Cycle index used to time-stamp observed events.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle in which any pulse output is high.
    always @(negedge clk) begin
        ev_t e;
        if (!rst && (fifo_wr_en || framing_err_o || overrun_o || break_o)) begin
            e.wr   = fifo_wr_en;
            e.data = fifo_wr_en ? fifo_wr_data : 8'h00;
            e.fe   = framing_err_o;
            e.ov   = overrun_o;
            e.brk  = break_o;
            e.t    = cyc;
            got_q.push_back(e);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_div(input int n);
        {DLM, DLL} = n[15:0];
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame of n clocks per bit; leaves rx_i at the stop level.
    task automatic drive_frame(input logic [7:0] data, input logic stop, input int n,
                               output int drop);
        rx_i = 1'b0;
        drop = cyc;
        wait_cycles(n);
        for (int i = 0; i < 8; i++) begin
            rx_i = data[i];
            wait_cycles(n);
        end
        rx_i = stop;
        wait_cycles(n);
    endtask

    // Reference model: what one frame must produce, and when. The stop
    // sample lands H+9N+1 cycles after the edge reaches the synchroniser
    // output, and the registered pulse is visible one cycle later.
    task automatic expect_frame(input logic [7:0] data, input logic stop, input logic full,
                                input int n, input int drop);
        ev_t e;
        int  h;
        h      = (n - 1) / 2;
        e.wr   = !full;
        e.data = full ? 8'h00 : data;
        e.fe   = !stop;
        e.ov   = full;
        e.brk  = !stop && (data == 8'h00);
        e.t    = drop + SYNC + h + 9 * n + 2;
        exp_q.push_back(e);
    endtask

    task automatic compare_events(input string tag);
        int diff;
        check($sformatf("%s.count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            $display("%s #%0d: wr=%0d data=%02h fe=%0d ov=%0d brk=%0d cyc=%0d (model cyc=%0d)",
                     tag, i, got_q[i].wr, got_q[i].data, got_q[i].fe, got_q[i].ov,
                     got_q[i].brk, got_q[i].t, exp_q[i].t);
            check($sformatf("%s[%0d].wr", tag, i), got_q[i].wr, exp_q[i].wr);
            check($sformatf("%s[%0d].data", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s[%0d].fe", tag, i), got_q[i].fe, exp_q[i].fe);
            check($sformatf("%s[%0d].ov", tag, i), got_q[i].ov, exp_q[i].ov);
            check($sformatf("%s[%0d].brk", tag, i), got_q[i].brk, exp_q[i].brk);
            diff = got_q[i].t - exp_q[i].t;
            check($sformatf("%s[%0d].latency_ok", tag, i), (diff >= -1 && diff <= 1), 1);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int drop;
        int n;
        int h;
        logic       seen_busy;
        logic [7:0] d;
        logic       st;
        logic       fl;
        logic [7:0] lb_bytes[4];

        lb_bytes[0] = 8'h00;
        lb_bytes[1] = 8'hFF;
        lb_bytes[2] = 8'h5A;
        lb_bytes[3] = 8'h81;

        // Reset state
        wait_cycles(3);
        check("reset.wr_en", fifo_wr_en, 0);
        check("reset.wr_data", fifo_wr_data, 0);
        check("reset.framing", framing_err_o, 0);
        check("reset.overrun", overrun_o, 0);
        check("reset.break", break_o, 0);
        check("reset.busy", busy_o, 0);
        rst = 1'b0;
        wait_cycles(5);

        // Basic frame 0xA5 at 16 clocks per bit
        n = 16;
        set_div(n);
        drive_frame(8'hA5, 1'b1, n, drop);
        expect_frame(8'hA5, 1'b1, 1'b0, n, drop);
        rx_i = 1'b1;
        wait_cycles(3 * n);
        compare_events("basic");
        check("basic.data_hold", fifo_wr_data, 8'hA5);
        check("basic.idle", busy_o, 0);

        // Back-to-back frames at 8 clocks per bit, as a transmitter would send them
        n = 8;
        set_div(n);
        for (int i = 0; i < 4; i++) begin
            drive_frame(lb_bytes[i], 1'b1, n, drop);
            expect_frame(lb_bytes[i], 1'b1, 1'b0, n, drop);
        end
        rx_i = 1'b1;
        wait_cycles(3 * n);
        compare_events("b2b");

        // Three-cycle glitch: must be rejected and busy must clear in time
        n = 16;
        h = (n - 1) / 2;
        set_div(n);
        seen_busy = 1'b0;
        rx_i = 1'b0;
        for (int k = 1; k <= h + SYNC + 2; k++) begin
            @(negedge clk);
            if (k == 3) rx_i = 1'b1;
            if (busy_o) seen_busy = 1'b1;
        end
        check("glitch.busy_seen", seen_busy, 1);
        check("glitch.busy_cleared", busy_o, 0);
        wait_cycles(3 * n);
        compare_events("glitch");

        // Frame 0x3C with a low stop bit, line then held low
        drive_frame(8'h3C, 1'b0, n, drop);
        expect_frame(8'h3C, 1'b0, 1'b0, n, drop);
        wait_cycles(3 * n);
        compare_events("framing");
        check("framing.wait_busy", busy_o, 1);
        rx_i = 1'b1;
        wait_cycles(2 * n);
        compare_events("framing_release");
        drive_frame(8'h5E, 1'b1, n, drop);
        expect_frame(8'h5E, 1'b1, 1'b0, n, drop);
        rx_i = 1'b1;
        wait_cycles(3 * n);
        compare_events("after_framing");

        // Break: line low for 40 bit times, one event only
        rx_i = 1'b0;
        drop = cyc;
        expect_frame(8'h00, 1'b0, 1'b0, n, drop);
        wait_cycles(40 * n);
        rx_i = 1'b1;
        wait_cycles(2 * n);
        compare_events("break");
        drive_frame(8'h12, 1'b1, n, drop);
        expect_frame(8'h12, 1'b1, 1'b0, n, drop);
        rx_i = 1'b1;
        wait_cycles(3 * n);
        compare_events("after_break");

        // Overrun: FIFO full throughout frame 0x77
        fifo_full = 1'b1;
        drive_frame(8'h77, 1'b1, n, drop);
        expect_frame(8'h77, 1'b1, 1'b1, n, drop);
        rx_i = 1'b1;
        wait_cycles(3 * n);
        fifo_full = 1'b0;
        compare_events("overrun");
        check("overrun.data_hold", fifo_wr_data, 8'h12);

        // Reset in the middle of a frame
        rx_i = 1'b0;
        wait_cycles(n);
        rx_i = 1'b1;
        wait_cycles(n + n / 2);
        check("midrst.busy_before", busy_o, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst.busy", busy_o, 0);
        check("midrst.wr_en", fifo_wr_en, 0);
        check("midrst.wr_data", fifo_wr_data, 0);
        check("midrst.framing", framing_err_o, 0);
        check("midrst.overrun", overrun_o, 0);
        check("midrst.break", break_o, 0);
        @(negedge clk);
        rx_i = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(20);
        drive_frame(8'hC3, 1'b1, n, drop);
        expect_frame(8'hC3, 1'b1, 1'b0, n, drop);
        rx_i = 1'b1;
        wait_cycles(3 * n);
        compare_events("after_reset");

        // Randomised frames: divisor, data, stop level and FIFO full vary
        for (int f = 0; f < 24; f++) begin
            n  = $urandom_range(4, 14);
            d  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 4) != 0);
            fl = ($urandom_range(0, 3) == 0);
            if (f % 6 == 5) d = 8'h00;
            set_div(n);
            fifo_full = fl;
            drive_frame(d, st, n, drop);
            expect_frame(d, st, fl, n, drop);
            rx_i = 1'b1;
            wait_cycles(2 * n + $urandom_range(0, 5));
        end
        fifo_full = 1'b0;
        wait_cycles(20);
        compare_events("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
